prv32_alu_mc: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle integer ALU. It executes the base RV32I ALU operations in one cycle and the RV32M multiply/divide/remainder operations iteratively, one bit per cycle. It sits in the EX stage behind a valid/ready handshake, so the pipeline stalls on in_ready/out_valid instead of assuming fixed latency. It also adds a flush input for branch/exception kill.

---
 rtl/prv32_alu_pkg.sv | 27 ++
 rtl/prv32_alu_comb.sv | 48 ++++
 rtl/prv32_alu_mc.sv | 165 ++++++++++++++++
 tb/tb_prv32_alu_mc.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/prv32_alu_pkg.sv
// Shared opcode encodings and FSM state type for the prv32 multi-cycle ALU.
package prv32_alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_PASSB = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_AND   = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_SLT   = 4'b1101;
  localparam logic [3:0] ALU_SLTU  = 4'b1111;

  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} alu_state_e;

endpackage

// File: rtl/prv32_alu_comb.sv
// Single-cycle base ALU: adder with carry/zero/overflow/sign flags, logic ops,
// shifter and set-less-than.
module prv32_alu_comb import prv32_alu_pkg::*; #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [SHW-1:0]  shamt_i,
  input  logic            itype_i,
  output logic [XLEN-1:0] r_o,
  output logic            cf_o,
  output logic            zf_o,
  output logic            vf_o,
  output logic            sf_o
);

  logic [XLEN:0]   sum;
  logic [SHW-1:0]  amt;

  // op[0] selects subtraction for every code, so flags exist for all base ops.
  assign sum  = op_i[0] ? ({1'b0, a_i} + {1'b0, ~b_i} + {{XLEN{1'b0}}, 1'b1})
                        : ({1'b0, a_i} + {1'b0, b_i});
  assign cf_o = sum[XLEN];
  assign zf_o = (sum[XLEN-1:0] == '0);
  assign sf_o = sum[XLEN-1];
  assign vf_o = a_i[XLEN-1] ^ ~b_i[XLEN-1] ^ sum[XLEN-1] ^ sum[XLEN];
  assign amt  = itype_i ? shamt_i : b_i[SHW-1:0];

  always_comb begin
    r_o = '0;
    case (op_i)
      ALU_ADD, ALU_SUB: r_o = sum[XLEN-1:0];
      ALU_PASSB:        r_o = b_i;
      ALU_OR:           r_o = a_i | b_i;
      ALU_AND:          r_o = a_i & b_i;
      ALU_XOR:          r_o = a_i ^ b_i;
      ALU_SRL:          r_o = a_i >> amt;
      ALU_SLL:          r_o = a_i << amt;
      ALU_SRA:          r_o = $unsigned($signed(a_i) >>> amt);
      ALU_SLT:          r_o = {{(XLEN-1){1'b0}}, sf_o ^ vf_o};
      ALU_SLTU:         r_o = {{(XLEN-1){1'b0}}, ~cf_o};
      default:          r_o = '0;
    endcase
  end

endmodule

// File: rtl/prv32_alu_mc.sv
// Multi-cycle RV32I/M ALU: base ops in one cycle, mul/div iteratively one bit per
// cycle, behind valid/ready handshakes with flush.
module prv32_alu_mc import prv32_alu_pkg::*; #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [SHW-1:0]  shamt,
  input  logic            itype,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] r,
  output logic            cf,
  output logic            zf,
  output logic            vf,
  output logic            sf
);

  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  alu_state_e      state_q;
  logic [SHW-1:0]  cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, opnd_q, r_q;
  logic            negRes_q, selHi_q;
  logic            cf_q, zf_q, vf_q, sf_q;

  logic [XLEN-1:0] aluR;
  logic            aluCf, aluZf, aluVf, aluSf;

  prv32_alu_comb #(.XLEN(XLEN)) uComb (
    .op_i    (op[3:0]),
    .a_i     (a),
    .b_i     (b),
    .shamt_i (shamt),
    .itype_i (itype),
    .r_o     (aluR),
    .cf_o    (aluCf),
    .zf_o    (aluZf),
    .vf_o    (aluVf),
    .sf_o    (aluSf)
  );

  logic            aSigned, bSigned, aNeg, bNeg, divZero, divOvf;
  logic [XLEN-1:0] magA, magB;

  // The iterative core works on magnitudes; result sign is fixed up at the end.
  always_comb begin
    aSigned = 1'b0;
    bSigned = 1'b0;
    case (op[2:0])
      M_MULH:        begin aSigned = 1'b1; bSigned = 1'b1; end
      M_MULHSU:      aSigned = 1'b1;
      M_DIV, M_REM:  begin aSigned = 1'b1; bSigned = 1'b1; end
      default:       ;
    endcase
    aNeg    = aSigned & a[XLEN-1];
    bNeg    = bSigned & b[XLEN-1];
    magA    = aNeg ? -a : a;
    magB    = bNeg ? -b : b;
    divZero = (b == '0);
    divOvf  = aSigned & (a == MinVal) & (b == '1);
  end

  logic [XLEN:0]     mulSum, divShift, divDiff;
  logic [XLEN-1:0]   hi_d, lo_d, divWord, finalRes;
  logic [2*XLEN-1:0] mulFull;

  // Multiply: shift-add into {hi,lo}. Divide: restoring, remainder in hi, quotient in lo.
  always_comb begin
    mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    divShift = {hi_q, lo_q[XLEN-1]};
    divDiff  = divShift - {1'b0, opnd_q};
    if (state_q == DIV) begin
      if (!divDiff[XLEN]) begin
        hi_d = divDiff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = divShift[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      {hi_d, lo_d} = {mulSum, lo_q[XLEN-1:1]};
    end
    mulFull  = negRes_q ? -{hi_d, lo_d} : {hi_d, lo_d};
    divWord  = selHi_q ? hi_d : lo_d;
    if (state_q == DIV)
      finalRes = negRes_q ? -divWord : divWord;
    else
      finalRes = selHi_q ? mulFull[2*XLEN-1:XLEN] : mulFull[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      negRes_q <= 1'b0;
      selHi_q  <= 1'b0;
      r_q      <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      vf_q     <= 1'b0;
      sf_q     <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (!op[4]) begin
              r_q     <= aluR;
              cf_q    <= aluCf;
              zf_q    <= aluZf;
              vf_q    <= aluVf;
              sf_q    <= aluSf;
              state_q <= DONE;
            end else if (op[2] && (divZero || divOvf)) begin
              r_q     <= divZero ? (op[1] ? a : '1) : (op[1] ? '0 : MinVal);
              {cf_q, zf_q, vf_q, sf_q} <= 4'b0000;
              state_q <= DONE;
            end else begin
              hi_q     <= '0;
              lo_q     <= op[2] ? magA : magB;
              opnd_q   <= op[2] ? magB : magA;
              negRes_q <= (op[2] && op[1]) ? aNeg : (aNeg ^ bNeg);
              selHi_q  <= op[2] ? op[1] : (op[1:0] != 2'b00);
              cnt_q    <= SHW'(XLEN-1);
              state_q  <= op[2] ? DIV : MUL;
            end
          end
        end
        MUL, DIV: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            r_q     <= finalRes;
            {cf_q, zf_q, vf_q, sf_q} <= 4'b0000;
            state_q <= DONE;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign r         = r_q;
  assign cf        = cf_q;
  assign zf        = zf_q;
  assign vf        = vf_q;
  assign sf        = sf_q;

endmodule

// File: tb/tb_prv32_alu_mc.sv
// Randomised and directed bench for prv32_alu_mc (XLEN=32) plus a small XLEN=16
// instance, checked against an arithmetic reference model.
module tb_prv32_alu_mc;
  import prv32_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, itype, out_ready;
  logic [4:0]  op, shamt;
  logic [31:0] a, b;
  logic        in_ready, out_valid, cf, zf, vf, sf;
  logic [31:0] r;

  logic        in_valid16, itype16, out_ready16;
  logic [4:0]  op16;
  logic [3:0]  shamt16;
  logic [15:0] a16, b16, r16;
  logic        in_ready16, out_valid16, cf16, zf16, vf16, sf16;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  prv32_alu_mc #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .shamt(shamt), .itype(itype), .out_valid(out_valid),
    .out_ready(out_ready), .r(r), .cf(cf), .zf(zf), .vf(vf), .sf(sf)
  );

  prv32_alu_mc #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid16), .in_ready(in_ready16),
    .op(op16), .a(a16), .b(b16), .shamt(shamt16), .itype(itype16), .out_valid(out_valid16),
    .out_ready(out_ready16), .r(r16), .cf(cf16), .zf(zf16), .vf(vf16), .sf(sf16)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: returns {r, cf, zf, vf, sf}.
  function automatic logic [35:0] modelAlu(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                           input logic [4:0] sh, input logic it);
    logic [32:0] s;
    logic [4:0]  amt;
    logic [31:0] res;
    logic        c, z, v, n;
    longint      ps;
    logic [63:0] pu;
    int          sx, sy;
    if (!o[4]) begin
      s   = o[0] ? ({1'b0, x} + {1'b0, ~y} + 33'd1) : ({1'b0, x} + {1'b0, y});
      c   = s[32];
      z   = (s[31:0] == 32'd0);
      n   = s[31];
      v   = x[31] ^ ~y[31] ^ s[31] ^ c;
      amt = it ? sh : y[4:0];
      case (o[3:0])
        4'b0000: res = x + y;
        4'b0001: res = x - y;
        4'b0011: res = y;
        4'b0100: res = x | y;
        4'b0101: res = x & y;
        4'b0111: res = x ^ y;
        4'b1000: res = x >> amt;
        4'b1001: res = x << amt;
        4'b1010: res = $unsigned($signed(x) >>> amt);
        4'b1101: res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        4'b1111: res = (x < y) ? 32'd1 : 32'd0;
        default: res = 32'd0;
      endcase
      return {res, c, z, v, n};
    end
    sx = int'(x);
    sy = int'(y);
    pu = {32'd0, x} * {32'd0, y};
    case (o[2:0])
      3'b000: res = pu[31:0];
      3'b001: begin ps = longint'(sx) * longint'(sy); res = ps[63:32]; end
      3'b010: begin ps = longint'(sx) * longint'({32'd0, y}); res = ps[63:32]; end
      3'b011: res = pu[63:32];
      3'b100: res = (y == 0) ? 32'hFFFFFFFF : (x == 32'h80000000 && y == 32'hFFFFFFFF) ? 32'h80000000 : 32'(sx / sy);
      3'b101: res = (y == 0) ? 32'hFFFFFFFF : x / y;
      3'b110: res = (y == 0) ? x : (x == 32'h80000000 && y == 32'hFFFFFFFF) ? 32'd0 : 32'(sx % sy);
      default: res = (y == 0) ? x : x % y;
    endcase
    return {res, 4'b0000};
  endfunction

  function automatic int modelLatency(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    if (!o[4]) return 1;
    if (o[2] && (y == 0 || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))) return 1;
    return 33;
  endfunction

  task automatic applyStimulus(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                               input logic [4:0] sh, input logic it, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    checkOutput("in_ready_before_accept", in_ready, 1);
    op = o; a = x; b = y; shamt = sh; itype = it; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 5'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom); itype = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 80) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic releaseResult();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checkOutput("in_ready_after_handshake", in_ready, 1);
    checkOutput("out_valid_after_handshake", out_valid, 0);
  endtask

  task automatic runOp(input string tag, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] sh, input logic it, input int holdCycles);
    int lat;
    logic [35:0] exp;
    exp = modelAlu(o, x, y, sh, it);
    applyStimulus(o, x, y, sh, it, lat);
    checkOutput({tag, "_latency"}, lat, modelLatency(o, x, y));
    repeat (holdCycles) begin
      @(posedge clk); #1;
      checkOutput({tag, "_hold_in_ready"}, in_ready, 0);
      checkOutput({tag, "_hold_out_valid"}, out_valid, 1);
    end
    checkOutput({tag, "_r"}, r, exp[35:4]);
    checkOutput({tag, "_flags"}, {cf, zf, vf, sf}, exp[3:0]);
    releaseResult();
  endtask

  // Kill an in-flight M op after ten iterations with either flush or reset.
  task automatic interruptOp(input string tag, input logic [4:0] o, input logic useReset);
    int seen = 0;
    @(negedge clk);
    op = o; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    if (useReset) rst = 1'b1; else flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    if (useReset) checkOutput({tag, "_r_cleared"}, r, 0);
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    checkOutput({tag, "_no_result"}, seen, 0);
    runOp({tag, "_add"}, {1'b0, ALU_ADD}, 32'd1, 32'd2, 5'd0, 1'b0, 0);
  endtask

  task automatic run16(input string tag, input logic [4:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [3:0] sh, input logic it, input logic [15:0] expR, input int expLat);
    int lat;
    @(negedge clk);
    op16 = o; a16 = x; b16 = y; shamt16 = sh; itype16 = it; in_valid16 = 1'b1;
    @(posedge clk); #1; in_valid16 = 1'b0; a16 = 16'($urandom);
    lat = 1;
    while (!out_valid16 && lat < 60) begin @(posedge clk); #1; lat++; end
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_r"}, r16, expR);
    @(negedge clk); out_ready16 = 1'b1;
    @(posedge clk); #1; out_ready16 = 1'b0;
    checkOutput({tag, "_in_ready"}, in_ready16, 1);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0] ro;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; shamt = '0; itype = 1'b0; out_ready = 1'b0;
    in_valid16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; shamt16 = '0; itype16 = 1'b0; out_ready16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_r", r, 0);
    checkOutput("reset_flags", {cf, zf, vf, sf}, 0);
    @(negedge clk); rst = 1'b0;

    runOp("sub_5_7", {1'b0, ALU_SUB}, 32'd5, 32'd7, 5'd0, 1'b0, 0);
    runOp("sltu_5_7", {1'b0, ALU_SLTU}, 32'd5, 32'd7, 5'd0, 1'b0, 0);
    runOp("mulh_min_min", {2'b10, M_MULH}, 32'h80000000, 32'h80000000, 5'd0, 1'b0, 0);
    runOp("mul_7_m3", {2'b11, M_MUL}, 32'd7, 32'hFFFFFFFD, 5'd0, 1'b0, 0);
    runOp("div_m7_2", {2'b10, M_DIV}, 32'hFFFFFFF9, 32'd2, 5'd0, 1'b0, 0);
    runOp("rem_m7_2", {2'b10, M_REM}, 32'hFFFFFFF9, 32'd2, 5'd0, 1'b0, 0);
    runOp("divu_by_zero", {2'b10, M_DIVU}, 32'd7, 32'd0, 5'd0, 1'b0, 0);
    runOp("div_overflow", {2'b10, M_DIV}, 32'h80000000, 32'hFFFFFFFF, 5'd0, 1'b0, 0);
    runOp("rem_by_zero", {2'b10, M_REM}, 32'hFFFFFFF9, 32'd0, 5'd0, 1'b0, 0);
    runOp("sra_imm", {1'b0, ALU_SRA}, 32'h80000000, 32'd0, 5'd4, 1'b1, 0);
    runOp("slt_backpressure", {1'b0, ALU_SLT}, 32'hFFFFFFF0, 32'd3, 5'd0, 1'b0, 10);

    interruptOp("flush_divu", {2'b10, M_DIVU}, 1'b0);
    interruptOp("reset_mul", {2'b10, M_MUL}, 1'b1);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 1) ro = {1'b1, 1'($urandom), 3'($urandom)};
      else ro = {1'b0, 4'($urandom)};
      runOp("random", ro, pickOperand(), pickOperand(), 5'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    run16("x16_mulhu", {2'b10, M_MULHU}, 16'hFFFF, 16'hFFFF, 4'd0, 1'b0, 16'hFFFE, 17);
    run16("x16_sra", {1'b0, ALU_SRA}, 16'h8000, 16'd0, 4'd4, 1'b1, 16'hF800, 1);
    run16("x16_div", {2'b10, M_DIV}, 16'hFFF9, 16'd2, 4'd0, 1'b0, 16'hFFFD, 17);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
